mmio_bridge: RTL and testbench
==============================

# mmio_bridge

Memory-mapped I/O bridge between the processor's data-memory port and dmem. Decodes the 12-bit word address from the processor and routes each access either to dmem or to a small bank of peripheral registers: LEDs, switches, a cycle counter and a down-counting timer with interrupt. Read data from both sources is returned with dmem's one-cycle synchronous latency, so the processor cannot tell the two apart.

## Interface
- MMIO_BASE, 12'hF00: first word address of the MMIO window; the window is MMIO_BASE..12'hFFF.
- LED_W, 16: LED register width.
- SW_W, 16: switch input width.
- clock  in  1  dmem clock domain; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- address_dmem  in  12  processor word address.
- data  in  32  processor write data.
- wren  in  1  processor write enable.
- q_dmem  out  32  read data returned to the processor.
- mem_address  out  12  address to dmem (passthrough of address_dmem).
- mem_data  out  32  write data to dmem (passthrough of data).
- mem_wren  out  1  dmem write enable: wren & ~mmio_hit.
- mem_q  in  32  dmem read data.
- led  out  LED_W  LED register.
- sw  in  SW_W  asynchronous switch inputs.
- timer_irq  out  1  level interrupt, equal to the pending bit.

## Operation
- mmio_hit = (address_dmem >= MMIO_BASE). Writes inside the window never reach dmem. Writes outside the window never change MMIO state.
- Register offsets from MMIO_BASE:
  - 0 LED: RW. Reads return {zero-ext led}.
  - 1 SW: RO. sw passes through a 2-flop synchronizer.
  - 2 CYCLE: 32-bit free-running counter, increments every clock and wraps FFFFFFFF->0. Any write clears it to 0.
  - 3 TIMER_LOAD: RW, 32 bit.
  - 4 TIMER_CTRL: bit0 EN (RW), bit1 AUTO (RW), bit2 PEND (read; write 1 clears). Other bits read 0.
  - 5 TIMER_COUNT: RO.
  - 6..FF: read 0; writes are ignored.
- Timer states:
  - IDLE: COUNT holds its value.
  - RUN: COUNT decrements each cycle.
- Writing CTRL with EN=1 while in IDLE loads COUNT<=LOAD and moves to RUN.
- Writing EN=0 in any state moves to IDLE; COUNT freezes.
- In RUN, when COUNT==1 or COUNT==0, the next edge sets PEND. Then:
  - if AUTO=1: COUNT<=LOAD and the timer stays in RUN.
  - otherwise: COUNT<=0, EN clears, and the timer goes to IDLE.
- LOAD=0 with EN set therefore expires one cycle after the enable.
- Simultaneous events:
  - W1C of PEND in the same cycle as an expiry: the set wins.
  - Write to CYCLE in the same cycle as the increment: the write wins (value 0).
  - Write to LOAD while in RUN: affects only the next reload.

## Timing
- Read latency is 1 clock. The address presented at edge N is registered along with mmio_hit and the MMIO read data. At N+1, q_dmem = registered hit ? registered MMIO data : mem_q.
- Writes take effect at the edge where wren is sampled. A read of the same register on the following cycle returns the new value.
- Switch path latency is 2 clocks from sw to the SW register, plus 1 clock of read latency.
- Reset values: led=0, q_dmem=0, registered hit=0, CYCLE=0, LOAD=0, CTRL=0, COUNT=0, timer IDLE, timer_irq=0, sync flops=0.
- mem_address, mem_data and mem_wren are combinational and follow their inputs, including during reset.
- Asserting reset mid-countdown drops timer_irq and returns the timer to IDLE asynchronously.

## Configuration
- MMIO_TIMER_EN defined: the timer is built as described above.
- MMIO_TIMER_EN undefined: no timer logic is built. Offsets 3–5 read 0 and ignore writes, and timer_irq is tied to 0. LED, SW and CYCLE are unaffected.

## Structure
- mmio_pkg holds:
  - register offset constants (OFF_LED..OFF_TCOUNT),
  - CTRL bit positions (CTRL_EN, CTRL_AUTO, CTRL_PEND),
  - the timer state enum (TMR_IDLE, TMR_RUN).
- One sub-module, mmio_timer, holds LOAD/CTRL/COUNT, the state machine and the irq. It is instantiated only under MMIO_TIMER_EN.
- Decode, LED, SW sync, CYCLE and the read mux stay in mmio_bridge.

## Test plan
- Write 0x1234 to address 0x005 -> mem_wren=1. Read 0x005 -> q_dmem=0x1234 one cycle later. led unchanged (0).
- Write 0xABCD to 0xF00 -> mem_wren=0, led=0xABCD next edge. Read 0xF00 -> 0x0000ABCD.
- sw=0x00F0 held -> read of 0xF01 issued 3 cycles later returns 0x000000F0. Write 0 to 0xF02, then read 10 cycles later -> 10 (±1 per the documented edge).
- LOAD=3, CTRL=0x1 -> COUNT reads 3,2,1. PEND and timer_irq rise 3 cycles after the enable and EN clears. Write CTRL=0x4 -> irq drops.
- LOAD=2, CTRL=0x3 -> irq set every 2 cycles with COUNT reloading. W1C in the same cycle as an expiry leaves PEND=1.
- Pull reset low mid-countdown -> led, irq, CYCLE and COUNT read 0 after release. With MMIO_TIMER_EN undefined, a read of 0xF03 returns 0.

Source files
------------

// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pkg
// Description : Shared constants for the MMIO bridge: register offsets within
//               the MMIO window, timer CTRL bit positions and the timer state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    // Word offsets from the window base
    localparam logic [11:0] OFF_LED    = 12'd0;
    localparam logic [11:0] OFF_SW     = 12'd1;
    localparam logic [11:0] OFF_CYCLE  = 12'd2;
    localparam logic [11:0] OFF_TLOAD  = 12'd3;
    localparam logic [11:0] OFF_TCTRL  = 12'd4;
    localparam logic [11:0] OFF_TCOUNT = 12'd5;

    // TIMER_CTRL bit positions
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_PEND = 2;

    // Timer state encoding
    typedef enum logic [0:0] {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_t;

endpackage
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
// Module      : mmio_timer
// Description : Down-counting timer with LOAD/CTRL/COUNT registers, optional
//               auto-reload and a sticky pending bit that drives the level
//               interrupt. Only built when MMIO_TIMER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef MMIO_TIMER_EN
module mmio_timer
    import mmio_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wr_load,
    input  logic        i_wr_ctrl,
    input  logic [31:0] i_wdata,
    input  logic [11:0] i_off,
    output logic [31:0] o_rdata,
    output logic        o_irq
);

    tmr_state_t  r_state;
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic        r_en;
    logic        r_auto;
    logic        r_pend;

    logic        w_disable;
    logic        w_expire;
    logic        w_pend_clr;

    // A disabling write freezes the count, so it also suppresses an expiry
    assign w_disable  = i_wr_ctrl & ~i_wdata[CTRL_EN];
    assign w_expire   = (r_state == TMR_RUN) && (r_count <= 32'd1) && !w_disable;
    assign w_pend_clr = i_wr_ctrl & i_wdata[CTRL_PEND];

    // Timer state machine, register writes and pending flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= TMR_IDLE;
            r_load  <= 32'd0;
            r_count <= 32'd0;
            r_en    <= 1'b0;
            r_auto  <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            if (i_wr_load) begin
                r_load <= i_wdata;
            end
            if (i_wr_ctrl) begin
                r_auto <= i_wdata[CTRL_AUTO];
            end
            // Expiry set takes priority over a simultaneous write-1-to-clear
            r_pend <= w_expire | (r_pend & ~w_pend_clr);

            case (r_state)
                TMR_IDLE: begin
                    if (i_wr_ctrl && i_wdata[CTRL_EN]) begin
                        r_count <= r_load;
                        r_en    <= 1'b1;
                        r_state <= TMR_RUN;
                    end
                end
                TMR_RUN: begin
                    if (w_disable) begin
                        r_en    <= 1'b0;
                        r_state <= TMR_IDLE;
                    end else if (w_expire) begin
                        if (r_auto) begin
                            r_count <= r_load;
                        end else begin
                            r_count <= 32'd0;
                            r_en    <= 1'b0;
                            r_state <= TMR_IDLE;
                        end
                    end else begin
                        r_count <= r_count - 32'd1;
                    end
                end
                default: begin
                    r_state <= TMR_IDLE;
                end
            endcase
        end
    end

    // Read mux for the timer's three offsets
    always_comb begin
        o_rdata = 32'd0;
        case (i_off)
            OFF_TLOAD: o_rdata = r_load;
            OFF_TCTRL: begin
                o_rdata[CTRL_EN]   = r_en;
                o_rdata[CTRL_AUTO] = r_auto;
                o_rdata[CTRL_PEND] = r_pend;
            end
            OFF_TCOUNT: o_rdata = r_count;
            default:    o_rdata = 32'd0;
        endcase
    end

    assign o_irq = r_pend;

endmodule
`endif
`default_nettype wire

// File: rtl/mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bridge
// Description : Splits processor data accesses between dmem and a bank of
//               peripheral registers (LED, SW, CYCLE, timer). MMIO reads are
//               registered so they match dmem's one-cycle read latency.
//               Timer is built only when MMIO_TIMER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter logic [11:0] MMIO_BASE = 12'hF00,
    parameter int          LED_W     = 16,
    parameter int          SW_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [11:0]      address_dmem,
    input  logic [31:0]      data,
    input  logic             wren,
    output logic [31:0]      q_dmem,
    output logic [11:0]      mem_address,
    output logic [31:0]      mem_data,
    output logic             mem_wren,
    input  logic [31:0]      mem_q,
    output logic [LED_W-1:0] led,
    input  logic [SW_W-1:0]  sw,
    output logic             timer_irq
);

    logic             w_hit;
    logic [11:0]      w_off;
    logic             w_wr_mmio;
    logic [31:0]      w_rdata;
    logic [31:0]      w_tmr_rdata;
    logic             w_tmr_irq;

    logic [LED_W-1:0] r_led;
    logic [SW_W-1:0]  r_sw_meta;
    logic [SW_W-1:0]  r_sw_sync;
    logic [31:0]      r_cycle;
    logic             r_hit;
    logic [31:0]      r_rdata;

    // Address decode; dmem-side signals pass straight through
    assign w_hit       = (address_dmem >= MMIO_BASE);
    assign w_off       = address_dmem - MMIO_BASE;
    assign w_wr_mmio   = wren & w_hit;
    assign mem_address = address_dmem;
    assign mem_data    = data;
    assign mem_wren    = wren & ~w_hit;

    // LED register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_led <= '0;
        end else if (w_wr_mmio && (w_off == OFF_LED)) begin
            r_led <= data[LED_W-1:0];
        end
    end

    // Two-flop synchronizer for the asynchronous switch inputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    // Free-running cycle counter; a write of any value clears it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cycle <= 32'd0;
        end else if (w_wr_mmio && (w_off == OFF_CYCLE)) begin
            r_cycle <= 32'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

`ifdef MMIO_TIMER_EN
    mmio_timer u_timer (
        .clk       (clock),
        .rst_n     (reset),
        .i_wr_load (w_wr_mmio && (w_off == OFF_TLOAD)),
        .i_wr_ctrl (w_wr_mmio && (w_off == OFF_TCTRL)),
        .i_wdata   (data),
        .i_off     (w_off),
        .o_rdata   (w_tmr_rdata),
        .o_irq     (w_tmr_irq)
    );
`else
    logic w_unused_tmr;
    assign w_tmr_rdata  = 32'd0;
    assign w_tmr_irq    = 1'b0;
    assign w_unused_tmr = ^data;
`endif

    // MMIO read mux, sampled with the address at the access edge
    always_comb begin
        w_rdata = 32'd0;
        if (w_hit) begin
            case (w_off)
                OFF_LED:    w_rdata = 32'(r_led);
                OFF_SW:     w_rdata = 32'(r_sw_sync);
                OFF_CYCLE:  w_rdata = r_cycle;
                OFF_TLOAD,
                OFF_TCTRL,
                OFF_TCOUNT: w_rdata = w_tmr_rdata;
                default:    w_rdata = 32'd0;
            endcase
        end
    end

    // Read pipeline stage matching dmem's synchronous latency
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hit   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_hit   <= w_hit;
            r_rdata <= w_rdata;
        end
    end

    assign q_dmem    = r_hit ? r_rdata : mem_q;
    assign led       = r_led;
    assign timer_irq = w_tmr_irq;

endmodule
`default_nettype wire

// File: tb/tb_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_bridge
// Description : Directed self-checking bench for mmio_bridge with a simple
//               synchronous dmem model. Timer checks follow MMIO_TIMER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mmio_bridge;

    logic        clock;
    logic        reset;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [11:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;
    logic [15:0] led;
    logic [15:0] sw;
    logic        timer_irq;

    logic [31:0] mem [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    mmio_bridge #(
        .MMIO_BASE (12'hF00),
        .LED_W     (16),
        .SW_W      (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_wren     (mem_wren),
        .mem_q        (mem_q),
        .led          (led),
        .sw           (sw),
        .timer_irq    (timer_irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous dmem model, one-cycle read latency
    always @(posedge clock) begin
        if (!reset) begin
            mem_q <= 32'd0;
        end else begin
            if (mem_wren) mem[mem_address] <= mem_data;
            mem_q <= mem[mem_address];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; write happens at the next posedge, returns at the following negedge
    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic exp_wren);
        address_dmem = a;
        data         = d;
        wren         = 1'b1;
        #1;
        check($sformatf("mem_wren@%03h", a), {31'd0, mem_wren}, {31'd0, exp_wren});
        @(negedge clock);
        wren = 1'b0;
    endtask

    // Called at a negedge; address captured at the next posedge, data checked at the following negedge
    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        address_dmem = a;
        wren         = 1'b0;
        @(negedge clock);
        check(tag, q_dmem, exp);
    endtask

    initial begin
        reset        = 1'b0;
        address_dmem = 12'h000;
        data         = 32'd0;
        wren         = 1'b0;
        sw           = 16'h0000;

        // Reset state and combinational passthrough during reset
        repeat (2) @(negedge clock);
        check("rst_q_dmem", q_dmem, 32'd0);
        check("rst_led", {16'd0, led}, 32'd0);
        check("rst_irq", {31'd0, timer_irq}, 32'd0);
        address_dmem = 12'h00A; data = 32'hCAFE0001; wren = 1'b1;
        #1;
        check("rst_mem_wren_lo", {31'd0, mem_wren}, 32'd1);
        check("rst_mem_address", {20'd0, mem_address}, 32'h00A);
        check("rst_mem_data", mem_data, 32'hCAFE0001);
        address_dmem = 12'hF00;
        #1;
        check("rst_mem_wren_hi", {31'd0, mem_wren}, 32'd0);
        wren = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        // dmem path
        wr(12'h005, 32'h00001234, 1'b1);
        rd("dmem_rd_005", 12'h005, 32'h00001234);
        check("led_after_dmem_wr", {16'd0, led}, 32'd0);

        // LED register, upper data bits dropped
        wr(12'hF00, 32'h1234ABCD, 1'b0);
        check("led_written", {16'd0, led}, 32'h0000ABCD);
        rd("led_rd", 12'hF00, 32'h0000ABCD);

        // Window boundary: 0xEFF is dmem
        wr(12'hEFF, 32'h00005A5A, 1'b1);
        check("led_after_EFF", {16'd0, led}, 32'h0000ABCD);
        rd("dmem_rd_EFF", 12'hEFF, 32'h00005A5A);

        // Unmapped offsets read 0 and ignore writes
        wr(12'hF06, 32'h11111111, 1'b0);
        wr(12'hFFF, 32'h22222222, 1'b0);
        rd("rd_F06", 12'hF06, 32'd0);
        rd("rd_FFF", 12'hFFF, 32'd0);
        check("led_after_unmapped", {16'd0, led}, 32'h0000ABCD);

        // Switch sync: two flops plus read latency
        sw = 16'h00F0;
        @(negedge clock);
        rd("sw_early", 12'hF01, 32'd0);
        rd("sw_synced", 12'hF01, 32'h000000F0);

        // Cycle counter cleared by a write, then counts every clock
        wr(12'hF02, 32'hFFFFFFFF, 1'b0);
        repeat (9) @(negedge clock);
        rd("cycle_9", 12'hF02, 32'd9);
        rd("cycle_10", 12'hF02, 32'd10);

`ifdef MMIO_TIMER_EN
        // One-shot countdown from 3
        wr(12'hF03, 32'd3, 1'b0);
        wr(12'hF04, 32'h1, 1'b0);
        rd("os_count3", 12'hF05, 32'd3);
        check("os_irq_lo1", {31'd0, timer_irq}, 32'd0);
        rd("os_count2", 12'hF05, 32'd2);
        check("os_irq_lo2", {31'd0, timer_irq}, 32'd0);
        rd("os_count1", 12'hF05, 32'd1);
        check("os_irq_hi", {31'd0, timer_irq}, 32'd1);
        rd("os_ctrl", 12'hF04, 32'h4);
        wr(12'hF04, 32'h4, 1'b0);
        check("os_irq_cleared", {31'd0, timer_irq}, 32'd0);
        rd("os_ctrl_clr", 12'hF04, 32'h0);

        // LOAD=0 expires one cycle after enable
        wr(12'hF03, 32'd0, 1'b0);
        wr(12'hF04, 32'h1, 1'b0);
        check("z_irq_lo", {31'd0, timer_irq}, 32'd0);
        @(negedge clock);
        check("z_irq_hi", {31'd0, timer_irq}, 32'd1);
        rd("z_ctrl", 12'hF04, 32'h4);
        wr(12'hF04, 32'h4, 1'b0);

        // Auto-reload with LOAD=2
        wr(12'hF03, 32'd2, 1'b0);
        wr(12'hF04, 32'h3, 1'b0);
        check("ar_irq_e0", {31'd0, timer_irq}, 32'd0);
        @(negedge clock);
        check("ar_irq_e1", {31'd0, timer_irq}, 32'd0);
        @(negedge clock);
        check("ar_irq_e2", {31'd0, timer_irq}, 32'd1);
        wr(12'hF04, 32'h7, 1'b0);
        check("ar_w1c", {31'd0, timer_irq}, 32'd0);
        @(negedge clock);
        check("ar_irq_e4", {31'd0, timer_irq}, 32'd1);
        rd("ar_reloaded", 12'hF05, 32'd2);
        wr(12'hF04, 32'h7, 1'b0);
        check("ar_w1c_vs_set", {31'd0, timer_irq}, 32'd1);
        rd("ar_ctrl", 12'hF04, 32'h7);
`else
        // Without the timer, its offsets are inert
        wr(12'hF03, 32'h0000DEAD, 1'b0);
        wr(12'hF04, 32'h1, 1'b0);
        rd("nt_load", 12'hF03, 32'd0);
        rd("nt_ctrl", 12'hF04, 32'd0);
        rd("nt_count", 12'hF05, 32'd0);
        check("nt_irq", {31'd0, timer_irq}, 32'd0);
`endif

        // Asynchronous reset mid-operation
        wr(12'hF00, 32'h00000077, 1'b0);
        check("led_pre_rst", {16'd0, led}, 32'h00000077);
`ifdef MMIO_TIMER_EN
        check("irq_pre_rst", {31'd0, timer_irq}, 32'd1);
`endif
        #2;
        reset = 1'b0;
        #1;
        check("async_led", {16'd0, led}, 32'd0);
        check("async_irq", {31'd0, timer_irq}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        rd("post_rst_cycle", 12'hF02, 32'd0);
        rd("post_rst_led", 12'hF00, 32'd0);
        rd("post_rst_count", 12'hF05, 32'd0);
        rd("post_rst_ctrl", 12'hF04, 32'd0);
        check("post_rst_irq", {31'd0, timer_irq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
